amba_apb_bridge: RTL and testbench
==================================

AMBA_APB_BRIDGE -- requirements
Module: amba_apb_bridge

Interface
REQ-001 Parameters SHALL be: AWIDTH, default amba_pkg AWIDTH, address width; DWIDTH, default amba_pkg DWIDTH, data width; PTIMEOUT, default 16, maximum ACCESS cycles waiting for pready.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- hready, in, 1, bus ready from the response mux.
- haddr, in, AWIDTH, AHB address.
- hwrite, in, 1, AHB write flag.
- hsize, in, 3, AHB size (ignored; all transfers are full-word).
- htrans, in, 2, AHB transfer type.
- hwdata, in, DWIDTH, AHB write data.
- hsel, in, 1, slave select from the decoder.
- hrdata, out, DWIDTH, read data to the mux.
- hreadyout, out, 1, slave ready to the mux.
- hresp, out, 1, 0 = OKAY, 1 = ERROR.
- paddr, out, AWIDTH, APB address.
- psel, out, 1, APB select.
- penable, out, 1, APB enable.
- pwrite, out, 1, APB write.
- pwdata, out, DWIDTH, APB write data.
- prdata, in, DWIDTH, APB read data.
- pready, in, 1, APB ready.
- pslverr, in, 1, APB slave error.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 FSM states SHALL be IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
REQ-005 Accept condition SHALL be hsel=1 AND hready=1 AND htrans in {NONSEQ(10), SEQ(11)}, sampled only in IDLE.
REQ-006 On accept: paddr<=haddr, pwrite<=hwrite, hreadyout<=0.
- Write: next state WDATA.
- Read: psel<=1 and next state SETUP.
REQ-007 WDATA (one cycle): pwdata<=hwdata, psel<=1, next state SETUP; hreadyout stays 0.
REQ-008 SETUP (one cycle): psel=1, penable=0; at the edge penable<=1, timeout counter<=0, next state ACCESS.
REQ-009 ACCESS: psel=1, penable=1. The counter increments each cycle pready=0; paddr, pwrite and pwdata SHALL stay stable.
REQ-010 ACCESS with pready=1, or with the counter reaching PTIMEOUT-1: psel<=0 and penable<=0.
- Read completed by pready: hrdata<=prdata.
- Read ended by timeout: hrdata<=0.
REQ-011 ACCESS-end, normal completion: hreadyout<=1, hresp<=0, next state IDLE.
REQ-012 ACCESS-end, error completion (see REQ-020): hreadyout<=0, hresp<=1, next state ERR1.
REQ-013 ERR1 -> ERR2: hreadyout<=1, hresp stays 1. ERR2 -> IDLE: hresp<=0. This is the two-cycle AHB error response.
REQ-014 Read latency SHALL be: accept edge to hreadyout=1 = 3 cycles with zero APB wait states, plus one cycle per pready=0 cycle in ACCESS. Write latency SHALL be one cycle more than read latency.
REQ-015 The following SHALL cause no transfer, keep hreadyout=1 and hresp=0, and leave APB outputs unchanged:
- htrans IDLE(00) or BUSY(01) with hsel=1;
- hsel=0;
- hready=0.
REQ-016 While hreadyout=0, AHB inputs SHALL be ignored. A back-to-back transfer is accepted in the IDLE cycle in which hreadyout=1.
REQ-017 The timeout counter SHALL be sized $clog2(PTIMEOUT+1) and SHALL NOT wrap. It is cleared on entry to ACCESS.
REQ-018 pready and timeout in the same cycle SHALL be treated as pready completion.

Reset
REQ-019 When rst_n=0 (asynchronous, at any state including mid-transfer), the block SHALL go to:
- state IDLE and counter 0;
- hreadyout=1, hresp=0, hrdata=0;
- paddr=0, pwdata=0, pwrite=0, psel=0, penable=0.
- An in-flight APB transfer is abandoned with no completion.

Configuration
REQ-020 Macro AMBA_APB_SLVERR_EN SHALL select error handling.
- Defined: pslverr=1 with pready=1, or a timeout, completes with the error path (REQ-012/013).
- Not defined: pslverr is ignored, hresp is constant 0, timeout completes as OKAY, and ERR1/ERR2 are unreachable.

Verification
REQ-021 Zero-wait write: NONSEQ write, haddr=0x0000_0040, hwdata=0xDEAD_BEEF, pready=1 -> psel high 2 cycles; paddr=0x40, pwdata=0xDEADBEEF, pwrite=1; hreadyout=1 four cycles after accept; hresp=0.
REQ-022 Wait-state read: NONSEQ read, haddr=0x0000_0080, pready low 3 ACCESS cycles, prdata=0x1234_5678 -> hrdata=0x12345678 with hreadyout=1 six cycles after accept.
REQ-023 Idle/busy filtering: hsel=1 with htrans=00, then 01, for 4 cycles each -> psel never asserts; hreadyout=1 throughout.
REQ-024 Error path, macro defined: read with pslverr=1 and pready=1 -> hresp=1 for 2 cycles, hreadyout 0 then 1. Timeout with pready stuck 0 -> same error response after 16 ACCESS cycles and hrdata=0. Macro undefined: both cases give hresp=0.
REQ-025 Back-to-back transfers and reset: write 0x10 followed immediately by read 0x14 -> second accept in the first hreadyout=1 cycle; paddr sequence 0x10 then 0x14. Assert rst_n=0 in ACCESS -> psel=0, penable=0, hreadyout=1 immediately, with no clock edge required.

Source files
------------

// File: rtl/amba_pkg.sv
// Shared AMBA bus widths used as parameter defaults by the bus bridges.
package amba_pkg;
    localparam int AWIDTH = 32;
    localparam int DWIDTH = 32;
endpackage

// File: rtl/amba_apb_bridge.sv
// AHB-Lite slave to APB master bridge, one outstanding transfer, registered outputs.
// Optional error signalling (pslverr / APB timeout -> AHB ERROR) enabled by `define AMBA_APB_SLVERR_EN.
//
// state  | meaning
// IDLE   | waiting for an AHB transfer, hreadyout=1
// WDATA  | capture AHB write data (data phase follows address phase)
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready or timeout
// ERR1   | first AHB error cycle, hreadyout=0 hresp=1
// ERR2   | second AHB error cycle, hreadyout=1 hresp=1
module amba_apb_bridge #(
    parameter int AWIDTH   = amba_pkg::AWIDTH,
    parameter int DWIDTH   = amba_pkg::DWIDTH,
    parameter int PTIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hready,
    input  logic [AWIDTH-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [1:0]        htrans,
    input  logic [DWIDTH-1:0] hwdata,
    input  logic              hsel,
    output logic [DWIDTH-1:0] hrdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [AWIDTH-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CW = $clog2(PTIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_SETUP,
        S_ACCESS,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          timeout_hit;
    logic          err_end;

    // NONSEQ and SEQ both have htrans[1] set; size is ignored (full-word only)
    assign accept      = hsel & hready & htrans[1];
    assign timeout_hit = (cnt == CW'(PTIMEOUT - 1));

`ifdef AMBA_APB_SLVERR_EN
    assign err_end = pready ? pslverr : 1'b1;
    logic unused_in;
    assign unused_in = ^{hsize, htrans[0]};
`else
    assign err_end = 1'b0;
    logic unused_in;
    assign unused_in = ^{hsize, htrans[0], pslverr};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        paddr     <= haddr;
                        pwrite    <= hwrite;
                        hreadyout <= 1'b0;
                        if (hwrite) begin
                            state <= S_WDATA;
                        end else begin
                            psel  <= 1'b1;
                            state <= S_SETUP;
                        end
                    end
                end
                S_WDATA: begin
                    pwdata <= hwdata;
                    psel   <= 1'b1;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    // pready wins over a timeout landing in the same cycle
                    if (pready || timeout_hit) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (!pwrite) begin
                            hrdata <= pready ? prdata : '0;
                        end
                        if (err_end) begin
                            hresp <= 1'b1;
                            state <= S_ERR1;
                        end else begin
                            hreadyout <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= S_ERR2;
                end
                S_ERR2: begin
                    hresp <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amba_apb_bridge.sv
// Self-checking bench for amba_apb_bridge against a latency/data model derived from the transfer rules.
module tb_amba_apb_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int PT = 16;
`ifdef AMBA_APB_SLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hready;
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [1:0]    htrans;
    logic [DW-1:0] hwdata;
    logic          hsel;
    logic [DW-1:0] hrdata;
    logic          hreadyout;
    logic          hresp;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int checks = 0;
    int passed = 0;
    logic [DW-1:0] exp_hrdata = '0;
    logic [AW-1:0] exp_paddr  = '0;

    amba_apb_bridge #(.AWIDTH(AW), .DWIDTH(DW), .PTIMEOUT(PT)) dut (
        .clk(clk), .rst_n(rst_n), .hready(hready), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hsel(hsel),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // One AHB transfer with an APB slave that stalls `waits` ACCESS cycles.
    task automatic do_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int waits, input bit serr, input logic [DW-1:0] rdata,
                           output int acc_edges);
        int  cyc, psel_n, hresp_n, acc_i, access, lat;
        bit  stable_ok, tout, err;
        hsel = 1'b1; hready = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hwdata = wdata;
        hsize = 3'b010;
        acc_edges = 0;
        do begin
            @(posedge clk); #1;
            acc_edges++;
        end while (hreadyout === 1'b1 && acc_edges < 8);
        checks++;
        if (hreadyout !== 1'b0) begin
            $display("FAIL accept addr=%h: hreadyout=%b after %0d edges, required 0", addr, hreadyout, acc_edges);
            hsel = 1'b0; htrans = 2'b00;
            return;
        end
        passed++;
        // AHB inputs change while the bridge is busy and must be ignored
        hready = 1'b0; htrans = 2'b11; haddr = $urandom; hwrite = $urandom_range(0, 1);
        cyc = 1; psel_n = 0; hresp_n = 0; acc_i = 0; stable_ok = 1'b1;
        while (hreadyout !== 1'b1 && cyc < 100) begin
            if (psel === 1'b1) psel_n++;
            if (hresp === 1'b1) hresp_n++;
            if (psel === 1'b1 && penable === 1'b1) begin
                if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) stable_ok = 1'b0;
                pready  = (acc_i >= waits);
                pslverr = serr & pready;
                prdata  = pready ? rdata : DW'($urandom);
                acc_i++;
            end else begin
                pready = 1'b0; pslverr = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            hwdata = $urandom;
        end
        if (hresp === 1'b1) hresp_n++;
        pready = 1'b0; pslverr = 1'b0;
        hsel = 1'b0; htrans = 2'b00; hready = 1'b1;

        tout   = (waits >= PT);
        access = tout ? PT : waits + 1;
        err    = ERR_EN && (tout || serr);
        lat    = (wr ? 1 : 0) + 1 + access + 1 + (err ? 1 : 0);
        if (!wr) exp_hrdata = tout ? '0 : rdata;
        exp_paddr = addr;

        checks++;
        if (cyc !== lat) $display("FAIL latency addr=%h: got %0d cycles, required %0d", addr, cyc, lat);
        else passed++;
        checks++;
        if (psel_n !== 1 + access) $display("FAIL psel_cycles addr=%h: got %0d, required %0d", addr, psel_n, 1 + access);
        else passed++;
        checks++;
        if (stable_ok !== 1'b1) $display("FAIL apb_stable addr=%h wr=%b: paddr/pwrite/pwdata wrong in ACCESS", addr, wr);
        else passed++;
        checks++;
        if (hresp_n !== (err ? 2 : 0)) $display("FAIL hresp_cycles addr=%h: got %0d, required %0d", addr, hresp_n, err ? 2 : 0);
        else passed++;
        checks++;
        if (hrdata !== exp_hrdata) $display("FAIL hrdata addr=%h: got %h, required %h", addr, hrdata, exp_hrdata);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hsel = 1'b0; hready = 1'b1; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'b010; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        #12;
        checks++;
        if ({hreadyout, hresp, psel, penable, pwrite} !== 5'b10000)
            $display("FAIL reset_ctrl: hreadyout,hresp,psel,penable,pwrite=%b, required 10000",
                     {hreadyout, hresp, psel, penable, pwrite});
        else passed++;
        checks++;
        if (paddr !== '0 || pwdata !== '0) $display("FAIL reset_apb: paddr=%h pwdata=%h, required 0", paddr, pwdata);
        else passed++;
        checks++;
        if (hrdata !== '0) $display("FAIL reset_hrdata: got %h, required 0", hrdata);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_write();
        int e;
        do_xfer(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0, 1'b0, '0, e);
        checks++;
        if (paddr !== 32'h40 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1 || hresp !== 1'b0)
            $display("FAIL write_regs: paddr=%h pwdata=%h pwrite=%b hresp=%b, required 40 deadbeef 1 0",
                     paddr, pwdata, pwrite, hresp);
        else passed++;
    endtask

    task automatic test_wait_read();
        int e;
        do_xfer(1'b0, 32'h0000_0080, '0, 3, 1'b0, 32'h1234_5678, e);
    endtask

    task automatic test_filter();
        logic [3:0] pat [4] = '{4'b1100, 4'b1101, 4'b0110, 4'b1011};
        bit ok;
        for (int p = 0; p < 4; p++) begin
            ok = 1'b1;
            {hsel, hready, htrans} = pat[p];
            for (int c = 0; c < 4; c++) begin
                haddr = $urandom; hwrite = $urandom_range(0, 1);
                @(posedge clk); #1;
                if (psel !== 1'b0 || hreadyout !== 1'b1 || hresp !== 1'b0 || paddr !== exp_paddr) ok = 1'b0;
            end
            checks++;
            if (!ok) $display("FAIL filter hsel,hready,htrans=%b: psel=%b hreadyout=%b hresp=%b paddr=%h, required 0 1 0 %h",
                              pat[p], psel, hreadyout, hresp, paddr, exp_paddr);
            else passed++;
        end
        hsel = 1'b0; hready = 1'b1; htrans = 2'b00;
    endtask

    task automatic test_error();
        int e;
        do_xfer(1'b0, 32'h0000_0100, '0, 0, 1'b1, 32'hA5A5_0F0F, e);
        do_xfer(1'b0, 32'h0000_0104, '0, PT + 4, 1'b0, 32'h5555_AAAA, e);
        do_xfer(1'b0, 32'h0000_0108, '0, PT - 1, 1'b0, 32'h0BAD_CAFE, e);
        do_xfer(1'b1, 32'h0000_010C, 32'h7777_1111, PT, 1'b0, '0, e);
        @(posedge clk); #1;
        checks++;
        if (hresp !== 1'b0 || hreadyout !== 1'b1) $display("FAIL err_recover: hresp=%b hreadyout=%b, required 0 1", hresp, hreadyout);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int e;
        do_xfer(1'b1, 32'h0000_0010, 32'hCAFE_0010, 1, 1'b0, '0, e);
        do_xfer(1'b0, 32'h0000_0014, '0, 0, 1'b0, 32'h0000_BEEF, e);
        checks++;
        if (e !== 1) $display("FAIL b2b_accept: accepted after %0d edges, required 1", e);
        else passed++;
        checks++;
        if (paddr !== 32'h14) $display("FAIL b2b_paddr: got %h, required 00000014", paddr);
        else passed++;
    endtask

    task automatic test_random();
        int e;
        bit wr, serr;
        int waits;
        for (int i = 0; i < 20; i++) begin
            wr    = $urandom_range(0, 1);
            serr  = ($urandom_range(0, 3) == 0);
            waits = ($urandom_range(0, 7) == 0) ? $urandom_range(PT - 2, PT + 2) : $urandom_range(0, 4);
            do_xfer(wr, AW'($urandom) & 32'hFFFF_FFFC, DW'($urandom), waits, serr, DW'($urandom), e);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(posedge clk); #1;
        hsel = 1'b1; hready = 1'b1; htrans = 2'b10; haddr = 32'h0000_0200; hwrite = 1'b0;
        pready = 1'b0;
        n = 0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        while (!(psel === 1'b1 && penable === 1'b1) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 10) $display("FAIL reach_access: psel=%b penable=%b, required 1 1", psel, penable);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable, hreadyout, hresp} !== 4'b0010)
            $display("FAIL async_reset: psel,penable,hreadyout,hresp=%b, required 0010", {psel, penable, hreadyout, hresp});
        else passed++;
        checks++;
        if (paddr !== '0 || hrdata !== '0) $display("FAIL async_reset_data: paddr=%h hrdata=%h, required 0 0", paddr, hrdata);
        else passed++;
        exp_paddr = '0; exp_hrdata = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (psel !== 1'b0 || hreadyout !== 1'b1) $display("FAIL post_reset_idle: psel=%b hreadyout=%b, required 0 1", psel, hreadyout);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_filter();
        test_error();
        test_back_to_back();
        test_random();
        test_filter();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
